cache_miss_arbiter: RTL

- Shares a single memory/bus port between up to 2**LOG_REQ cache miss requesters, such as the I-cache, the D-cache and the prefetcher.
- Selects one requester at a time with rotating (round-robin) priority and holds the grant for the whole bus transaction.
- Tracks the transaction through request, accept and completion.
- A watchdog aborts transactions that never complete.

---
 rtl/cache_miss_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cache_miss_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_miss_arbiter                                                         |
// | Round-robin arbiter sharing one memory port among cache miss requesters,   |
// | holding the grant through request/accept/complete, with a watchdog abort.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cache_miss_arbiter #(
  parameter int LOG_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [(2**LOG_REQ)-1:0]   req,
  output logic [(2**LOG_REQ)-1:0]   gnt,
  output logic [LOG_REQ-1:0]        gnt_idx,
  output logic                      gnt_valid,
  output logic                      bus_req,
  input  logic                      bus_ack,
  input  logic                      bus_done,
  output logic [(2**LOG_REQ)-1:0]   done,
  output logic                      timeout_err
);

  localparam int          c_N        = 2**LOG_REQ;
  localparam logic [15:0] c_WD_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_N-1:0]     r_gnt;
  logic [c_N-1:0]     w_gnt_nxt;
  logic [LOG_REQ-1:0] r_gnt_idx;
  logic [LOG_REQ-1:0] w_gnt_idx_nxt;
  logic               r_gnt_valid;
  logic [LOG_REQ-1:0] r_last_ptr;
  logic [LOG_REQ-1:0] w_last_ptr_nxt;
  logic [c_N-1:0]     r_done;
  logic [c_N-1:0]     w_done_nxt;
  logic               r_timeout_err;
  logic               w_timeout_nxt;
  logic [15:0]        r_wd;
  logic [15:0]        w_wd_nxt;
  logic               w_finish;
  logic               w_release;

  logic [LOG_REQ-1:0] w_win_idx;
  logic               w_win_found;
  logic [LOG_REQ-1:0] w_cand;

  // Scan starts just after the last served requester; the final candidate wraps to last_ptr itself.
  always_comb begin
    w_win_idx   = r_last_ptr;
    w_win_found = 1'b0;
    w_cand      = '0;
    for (int i = 1; i <= c_N; i++) begin
      w_cand = r_last_ptr + LOG_REQ'(i);
      if (!w_win_found && req[w_cand]) begin
        w_win_idx   = w_cand;
        w_win_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_last_ptr_nxt = r_last_ptr;
    w_done_nxt     = '0;
    w_timeout_nxt  = 1'b0;
    w_wd_nxt       = r_wd;
    w_finish       = 1'b0;
    w_release      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_gnt_nxt            = '0;
          w_gnt_nxt[w_win_idx] = 1'b1;
          w_gnt_idx_nxt        = w_win_idx;
          w_state_nxt          = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!req[r_gnt_idx]) begin
          w_release = 1'b1;
        end else if (bus_ack) begin
          if (bus_done) begin
            w_finish = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
            w_wd_nxt    = '0;
          end
        end
      end
      S_BUSY: begin
        if (bus_done) begin
          w_finish = 1'b1;
        end else if (r_wd >= c_WD_LIMIT) begin
          // Abort moves priority past the stuck requester, like a completion.
          w_timeout_nxt  = 1'b1;
          w_last_ptr_nxt = r_gnt_idx;
          w_release      = 1'b1;
        end else if (r_wd != 16'hFFFF) begin
          w_wd_nxt = r_wd + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_release   = 1'b1;
      end
    endcase

    if (w_finish) begin
      w_done_nxt     = r_gnt;
      w_last_ptr_nxt = r_gnt_idx;
      w_release      = 1'b1;
    end

    if (w_release) begin
      w_gnt_nxt     = '0;
      w_gnt_idx_nxt = '0;
      w_state_nxt   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_gnt         <= '0;
      r_gnt_idx     <= '0;
      r_gnt_valid   <= 1'b0;
      r_last_ptr    <= '1;
      r_done        <= '0;
      r_timeout_err <= 1'b0;
      r_wd          <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_gnt         <= w_gnt_nxt;
      r_gnt_idx     <= w_gnt_idx_nxt;
      r_gnt_valid   <= |w_gnt_nxt;
      r_last_ptr    <= w_last_ptr_nxt;
      r_done        <= w_done_nxt;
      r_timeout_err <= w_timeout_nxt;
      r_wd          <= w_wd_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign gnt_idx     = r_gnt_idx;
  assign gnt_valid   = r_gnt_valid;
  assign bus_req     = (r_state == S_GRANT);
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
